// File: rtl/pipe_stage_pkg.sv
// Shared types and defaults for the reusable pipeline-stage register.
//
// Contents:
//   PIPE_CTRL_WIDTH / PIPE_DATA_WIDTH  default bundle widths
//   m_event_e                          what happens to the main register on the next edge
//
// Optional feature macro used by the stage: PIPE_SKID_EN.
package pipe_stage_pkg;

    localparam int unsigned PIPE_CTRL_WIDTH = 8;
    localparam int unsigned PIPE_DATA_WIDTH = 32;

    // Next-edge action for the main register.
    typedef enum logic [1:0] {
        EvHold,   // keep current entry
        EvLoad,   // take a new entry (from skid or input)
        EvBubble, // become empty; ctrl forced to 0, data kept
        EvFlush   // discard; same effect as bubble, highest priority
    } m_event_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Skid register S for pipe_stage: holds one extra entry while the main register
// is stalled, and hands it back when the main register drains.
//
// Only built when PIPE_SKID_EN is defined; otherwise this file is empty.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   flush_i      drop the held entry (highest priority)
//   load_i       capture ctrl_i/data_i
//   drain_i      entry is being moved into the main register
//   ctrl_i       control bundle to capture
//   data_i       data bundle to capture
//   valid_o      S holds an entry
//   ctrl_o       held control bundle (0 when empty)
//   data_o       held data bundle
`ifdef PIPE_SKID_EN
module pipe_skid_buf #(
    parameter int unsigned CTRL_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  load_i,
    input  logic                  drain_i,
    input  logic [CTRL_WIDTH-1:0] ctrl_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  valid_o,
    output logic [CTRL_WIDTH-1:0] ctrl_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic                  valid_q, valid_d;
    logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    // load and drain never coincide: load needs an input fire, which needs S empty.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (flush_i || drain_i) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (load_i) begin
            valid_d = 1'b1;
            ctrl_d  = ctrl_i;
            data_d  = data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule
`endif

// File: rtl/pipe_stage.sv
// Reusable pipeline-stage register carrying a control and a data bundle between
// core stages with a valid/ready handshake, stall back-pressure, flush and
// bubble insertion.
//
// Configuration macro: PIPE_SKID_EN
//   defined   - two-entry stage (main + skid register), in_ready_o is registered
//   undefined - single-entry stage, in_ready_o = ~valid | out_ready_i (combinational)
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   flush_i       discard all held entries; a same-cycle input is dropped
//   in_valid_i    upstream entry valid
//   in_ready_o    stage accepts an entry this cycle
//   in_ctrl_i     upstream control bundle
//   in_data_i     upstream data bundle
//   out_valid_o   output entry valid
//   out_ready_i   downstream accepts the output entry
//   out_ctrl_o    control bundle, 0 whenever out_valid_o = 0
//   out_data_o    data bundle (not cleared by bubbles)
module pipe_stage
    import pipe_stage_pkg::*;
#(
    parameter int unsigned CTRL_WIDTH = PIPE_CTRL_WIDTH,
    parameter int unsigned DATA_WIDTH = PIPE_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [CTRL_WIDTH-1:0] in_ctrl_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [CTRL_WIDTH-1:0] out_ctrl_o,
    output logic [DATA_WIDTH-1:0] out_data_o
);

    logic                  m_valid_q, m_valid_d;
    logic [CTRL_WIDTH-1:0] m_ctrl_q, m_ctrl_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;

    logic                  in_fire;
    logic                  out_fire;
    logic [CTRL_WIDTH-1:0] src_ctrl;
    logic [DATA_WIDTH-1:0] src_data;
    m_event_e              m_ev;

    assign out_fire = m_valid_q & out_ready_i;
    assign in_fire  = in_valid_i & in_ready_o;

`ifdef PIPE_SKID_EN
    logic                  s_valid;
    logic [CTRL_WIDTH-1:0] s_ctrl;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  m_load;
    logic                  s_load;
    logic                  s_drain;

    assign m_load  = ~m_valid_q | out_fire;
    // Second entry parks in S only while M is stuck.
    assign s_load  = in_fire & m_valid_q & ~out_fire;
    assign s_drain = m_load & s_valid;

    // Registered ready: depends only on S, never on out_ready_i.
    assign in_ready_o = ~s_valid;

    // S is older than anything on the input, so it always wins.
    assign src_ctrl = s_valid ? s_ctrl : in_ctrl_i;
    assign src_data = s_valid ? s_data : in_data_i;

    pipe_skid_buf #(
        .CTRL_WIDTH (CTRL_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush_i),
        .load_i  (s_load),
        .drain_i (s_drain),
        .ctrl_i  (in_ctrl_i),
        .data_i  (in_data_i),
        .valid_o (s_valid),
        .ctrl_o  (s_ctrl),
        .data_o  (s_data)
    );

    always_comb begin
        m_ev = EvHold;
        if (flush_i) begin
            m_ev = EvFlush;
        end else if (m_load) begin
            m_ev = (s_valid || in_fire) ? EvLoad : EvBubble;
        end
    end
`else
    assign in_ready_o = ~m_valid_q | out_ready_i;
    assign src_ctrl   = in_ctrl_i;
    assign src_data   = in_data_i;

    always_comb begin
        m_ev = EvHold;
        if (flush_i) begin
            m_ev = EvFlush;
        end else if (in_fire) begin
            m_ev = EvLoad;
        end else if (out_fire) begin
            m_ev = EvBubble;
        end
    end
`endif

    // Bubbles and flushes zero ctrl so a dead slot can never write state downstream.
    always_comb begin
        m_valid_d = m_valid_q;
        m_ctrl_d  = m_ctrl_q;
        m_data_d  = m_data_q;
        unique case (m_ev)
            EvLoad: begin
                m_valid_d = 1'b1;
                m_ctrl_d  = src_ctrl;
                m_data_d  = src_data;
            end
            EvBubble, EvFlush: begin
                m_valid_d = 1'b0;
                m_ctrl_d  = '0;
            end
            EvHold: ;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            m_ctrl_q  <= '0;
            m_data_q  <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_ctrl_q  <= m_ctrl_d;
            m_data_q  <= m_data_d;
        end
    end

    assign out_valid_o = m_valid_q;
    assign out_ctrl_o  = m_ctrl_q;
    assign out_data_o  = m_data_q;

endmodule

// File: tb/tb_pipe_stage.sv
// Bench for pipe_stage. The reference model treats the stage as a bounded FIFO
// (capacity 2 with PIPE_SKID_EN, 1 without); the driver pushes accepted entries
// into a scoreboard queue and a separate monitor compares the DUT outputs against
// the queue head, popping on each output fire.
module tb_pipe_stage;

    localparam int unsigned CW = 8;
    localparam int unsigned DW = 32;
`ifdef PIPE_SKID_EN
    localparam int unsigned CAP = 2;
`else
    localparam int unsigned CAP = 1;
`endif

    logic          clk         = 1'b0;
    logic          rst_n       = 1'b0;
    logic          flush_i     = 1'b0;
    logic          in_valid_i  = 1'b0;
    logic          in_ready_o;
    logic [CW-1:0] in_ctrl_i   = '0;
    logic [DW-1:0] in_data_i   = '0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;
    logic [CW-1:0] out_ctrl_o;
    logic [DW-1:0] out_data_o;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    ent_t sb[$];
    int   n_cmp  = 0;
    int   n_err  = 0;
    bit   mon_en = 1'b0;

    always #5 clk = ~clk;

    pipe_stage #(
        .CTRL_WIDTH (CW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_ctrl_i   (in_ctrl_i),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_ctrl_o  (out_ctrl_o),
        .out_data_o  (out_data_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Accept rule of a bounded FIFO: with a skid slot, room exists while fewer
    // than two entries are held; without one, only an empty or draining stage accepts.
    function automatic bit model_ready(input int unsigned held, input logic ordy);
        if (CAP == 2) return held < 2;
        return (held == 0) || (ordy == 1'b1);
    endfunction

    // Monitor: samples 1 time unit after the falling edge, before the driver
    // updates the model for this cycle.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                chk("out_valid", 64'(out_valid_o), 64'(sb.size() != 0));
                chk("in_ready", 64'(in_ready_o), 64'(model_ready(sb.size(), out_ready_i)));
                if (out_valid_o && sb.size() != 0) begin
                    chk("out_ctrl", 64'(out_ctrl_o), 64'(sb[0].c));
                    chk("out_data", 64'(out_data_o), 64'(sb[0].d));
                    if (out_ready_i) void'(sb.pop_front());
                end else if (!out_valid_o) begin
                    chk("bubble_ctrl", 64'(out_ctrl_o), 64'(0));
                end
            end
        end
    end

    // One cycle of stimulus; the model decides acceptance from its own occupancy.
    task automatic cycle(input bit v, input int unsigned c, input int unsigned d,
                         input bit ordy, input bit fl);
        bit   fire;
        ent_t e;
        @(negedge clk);
        in_valid_i  = v;
        in_ctrl_i   = CW'(c);
        in_data_i   = DW'(d);
        out_ready_i = ordy;
        flush_i     = fl;
        fire        = v && model_ready(sb.size(), ordy);
        #2;
        if (fl) begin
            sb.delete();
        end else if (fire) begin
            e.c = CW'(c);
            e.d = DW'(d);
            sb.push_back(e);
        end
    endtask

    // Pulse reset for half a cycle while the stage is stalled.
    task automatic reset_mid_stall();
        @(negedge clk);
        in_valid_i  = 1'b0;
        flush_i     = 1'b0;
        out_ready_i = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(out_valid_o), 64'(0));
        chk("rst_mid_ctrl", 64'(out_ctrl_o), 64'(0));
        chk("rst_mid_data", 64'(out_data_o), 64'(0));
        chk("rst_mid_ready", 64'(in_ready_o), 64'(1));
        sb.delete();
        #4;
        rst_n = 1'b1;
    endtask

    initial begin
        #2;
        chk("reset_valid", 64'(out_valid_o), 64'(0));
        chk("reset_ctrl", 64'(out_ctrl_o), 64'(0));
        chk("reset_data", 64'(out_data_o), 64'(0));
        chk("reset_ready", 64'(in_ready_o), 64'(1));
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Back-to-back stream
        for (int i = 1; i <= 4; i++) cycle(1'b1, i, i * 16, 1'b1, 1'b0);
        cycle(1'b0, 0, 0, 1'b1, 1'b0);

        // Stall then release
        cycle(1'b1, 8'h05, 32'hAA, 1'b1, 1'b0);
        cycle(1'b1, 8'h06, 32'hBB, 1'b0, 1'b0);
        cycle(1'b0, 0, 0, 1'b0, 1'b0);
        cycle(1'b0, 0, 0, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 0, 0, 1'b1, 1'b0);

        // Flush with the stage full and a simultaneous input
        cycle(1'b1, 8'h07, 32'h1, 1'b0, 1'b0);
        cycle(1'b1, 8'h08, 32'h2, 1'b0, 1'b0);
        cycle(1'b1, 8'h09, 32'hCC, 1'b0, 1'b1);
        repeat (2) cycle(1'b0, 0, 0, 1'b1, 1'b0);

        // Bubble inside a ctrl=0xFF stream
        cycle(1'b1, 8'hFF, 1, 1'b1, 1'b0);
        cycle(1'b1, 8'hFF, 2, 1'b1, 1'b0);
        cycle(1'b0, 8'hFF, 3, 1'b1, 1'b0);
        cycle(1'b1, 8'hFF, 4, 1'b1, 1'b0);
        cycle(1'b0, 0, 0, 1'b1, 1'b0);

        // Reset during a stall
        cycle(1'b1, 8'h0A, 5, 1'b0, 1'b0);
        cycle(1'b1, 8'h0B, 6, 1'b0, 1'b0);
        reset_mid_stall();
        cycle(1'b0, 0, 0, 1'b1, 1'b0);

        // Full stage with out_ready toggled 0 -> 1
        cycle(1'b1, 8'h0C, 7, 1'b0, 1'b0);
        cycle(1'b1, 8'h0D, 8, 1'b0, 1'b0);
        cycle(1'b1, 8'h0D, 8, 1'b1, 1'b0);
        cycle(1'b1, 8'h0E, 9, 1'b1, 1'b0);
        cycle(1'b1, 8'h0F, 10, 1'b1, 1'b0);
        cycle(1'b0, 0, 0, 1'b1, 1'b0);

        // Randomised traffic with varying downstream back-pressure
        for (int seg = 0; seg < 12; seg++) begin
            int unsigned rdy_pct;
            rdy_pct = $urandom_range(100, 10);
            for (int k = 0; k < 60; k++) begin
                cycle(($urandom_range(99, 0) < 75), $urandom, $urandom,
                      ($urandom_range(99, 0) < rdy_pct), ($urandom_range(31, 0) == 0));
            end
        end

        repeat (4) cycle(1'b0, 0, 0, 1'b1, 1'b0);
        @(negedge clk);
        #3;
        chk("drained", 64'(sb.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
